// File: rtl/pico_ram_ctrl.sv
// Bridges the picorv32 native memory bus onto one single-port RAM port inside a fixed address window.
// The RAM has no byte enables, so partial stores read the word, merge the strobed bytes and write it back.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_IDLE       | waiting for a selected request; latches address/data/strobes
// S_RD_ISSUE   | RAM samples ram_addr
// S_RD_CAPTURE | ram_rdata valid; return it (read) or merge it (partial write)
// S_WR_ISSUE   | ram_wr high for this single cycle
// S_ACK        | mem_ready high for this single cycle; new requests not accepted
module pico_ram_ctrl #(
    parameter int          AW        = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_wdata,
    input  logic [3:0]    mem_wstrb,
    output logic [31:0]   mem_rdata,
    output logic          ram_wr,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_CAPTURE,
        S_WR_ISSUE,
        S_ACK
    } state_t;

    localparam logic [31-AW-2:0] W_TAG = BASE_ADDR[31:AW+2];

    state_t        r_state;
    logic          r_mem_ready;
    logic          r_ram_wr;
    logic [31:0]   r_mem_rdata;
    logic [AW-1:0] r_ram_addr;
    logic [31:0]   r_ram_wdata;
    logic [3:0]    r_wstrb_q;
    logic [31:0]   r_wdata_q;

    state_t        w_state;
    logic          w_mem_ready;
    logic          w_ram_wr;
    logic [31:0]   w_mem_rdata;
    logic [AW-1:0] w_ram_addr;
    logic [31:0]   w_ram_wdata;
    logic [3:0]    w_wstrb_q;
    logic [31:0]   w_wdata_q;
    logic [31:0]   w_merge;
    logic          w_sel;
    logic          w_unused;

    // Byte-offset bits never reach the RAM; only whole words are addressed.
    assign w_unused = ^mem_addr[1:0];
    assign w_sel    = mem_valid && (mem_addr[31:AW+2] == W_TAG);

    always_comb begin
        w_merge = ram_rdata;
        for (int i = 0; i < 4; i++) begin
            if (r_wstrb_q[i]) begin
                w_merge[8*i +: 8] = r_wdata_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_state     = r_state;
        w_mem_ready = 1'b0;
        w_ram_wr    = 1'b0;
        w_mem_rdata = r_mem_rdata;
        w_ram_addr  = r_ram_addr;
        w_ram_wdata = r_ram_wdata;
        w_wstrb_q   = r_wstrb_q;
        w_wdata_q   = r_wdata_q;
        case (r_state)
            S_IDLE: begin
                if (w_sel) begin
                    w_ram_addr = mem_addr[AW+1:2];
                    w_wstrb_q  = mem_wstrb;
                    w_wdata_q  = mem_wdata;
                    if (mem_wstrb == 4'hF) begin
                        w_ram_wdata = mem_wdata;
                        w_ram_wr    = 1'b1;
                        w_state     = S_WR_ISSUE;
                    end else begin
                        w_state = S_RD_ISSUE;
                    end
                end
            end
            S_RD_ISSUE: begin
                w_state = S_RD_CAPTURE;
            end
            S_RD_CAPTURE: begin
                if (r_wstrb_q == 4'h0) begin
                    w_mem_rdata = ram_rdata;
                    w_mem_ready = 1'b1;
                    w_state     = S_ACK;
                end else begin
                    w_ram_wdata = w_merge;
                    w_ram_wr    = 1'b1;
                    w_state     = S_WR_ISSUE;
                end
            end
            S_WR_ISSUE: begin
                w_mem_ready = 1'b1;
                w_state     = S_ACK;
            end
            S_ACK: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_mem_ready <= 1'b0;
            r_ram_wr    <= 1'b0;
            r_mem_rdata <= '0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_wstrb_q   <= '0;
            r_wdata_q   <= '0;
        end else begin
            r_state     <= w_state;
            r_mem_ready <= w_mem_ready;
            r_ram_wr    <= w_ram_wr;
            r_mem_rdata <= w_mem_rdata;
            r_ram_addr  <= w_ram_addr;
            r_ram_wdata <= w_ram_wdata;
            r_wstrb_q   <= w_wstrb_q;
            r_wdata_q   <= w_wdata_q;
        end
    end

    assign mem_ready = r_mem_ready;
    assign ram_wr    = r_ram_wr;
    assign mem_rdata = r_mem_rdata;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;

endmodule

// File: tb/tb_pico_ram_ctrl.sv
// Bench for pico_ram_ctrl: a registered-read RAM behind the DUT, and a word-array model of
// what memory should hold, checked after directed and random bus transactions.
module tb_pico_ram_ctrl;

    localparam int          AW    = 12;
    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int          DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          resetn;
    logic          mem_valid;
    logic          mem_ready;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic [31:0]   mem_rdata;
    logic          ram_wr;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    logic          ram_clr;
    logic [31:0]   ram_mem [0:DEPTH-1];
    logic [31:0]   ref_mem [0:DEPTH-1];
    logic [31:0]   last_rd;

    int            wr_cnt;
    int            rdy_cnt;
    logic [AW-1:0] last_wr_addr;
    logic [31:0]   last_wr_data;

    int            err_cnt = 0;
    int            chk_cnt = 0;

    always #5 clk = ~clk;

    pico_ram_ctrl #(.AW(AW), .BASE_ADDR(BASE)) u_dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .ram_wr    (ram_wr),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // RAM primitive: registered read, read-before-write
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < DEPTH; i++) ram_mem[i] <= '0;
            ram_rdata <= '0;
        end else begin
            ram_rdata <= ram_mem[ram_addr];
            if (ram_wr) ram_mem[ram_addr] <= ram_wdata;
        end
    end

    always @(posedge clk) begin
        if (ram_clr) begin
            wr_cnt       <= 0;
            rdy_cnt      <= 0;
            last_wr_addr <= '0;
            last_wr_data <= '0;
        end else begin
            if (ram_wr) begin
                wr_cnt       <= wr_cnt + 1;
                last_wr_addr <= ram_addr;
                last_wr_data <= ram_wdata;
            end
            if (mem_ready) rdy_cnt <= rdy_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic do_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int            wr0;
        int            rdy0;
        int            lat;
        int            exp_lat;
        bit            got;
        bit            hit;
        logic [AW-1:0] idx;
        logic [31:0]   merged;
        hit = (a[31:AW+2] == BASE[31:AW+2]);
        idx = a[AW+1:2];
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        wr0  = wr_cnt;
        rdy0 = rdy_cnt;
        if (!hit) begin
            repeat (8) @(negedge clk);
            mem_valid = 1'b0;
            chk("miss_ready", rdy_cnt - rdy0, 0);
            chk("miss_wr", wr_cnt - wr0, 0);
            return;
        end
        exp_lat = (s == 4'hF) ? 2 : (s == 4'h0) ? 3 : 4;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (mem_ready) got = 1'b1;
        end
        mem_valid = 1'b0;
        chk("ready_seen", {31'd0, got}, 1);
        chk("latency", lat, exp_lat);
        if (s == 4'h0) begin
            chk("rdata", mem_rdata, ref_mem[idx]);
            chk("read_no_wr", wr_cnt - wr0, 0);
            last_rd = ref_mem[idx];
        end else begin
            merged = ref_mem[idx];
            for (int b = 0; b < 4; b++) if (s[b]) merged[8*b +: 8] = d[8*b +: 8];
            chk("rdata_hold", mem_rdata, last_rd);
            chk("wr_count", wr_cnt - wr0, 1);
            chk("wr_addr", {20'd0, last_wr_addr}, {20'd0, idx});
            chk("wr_data", last_wr_data, merged);
            ref_mem[idx] = merged;
        end
    endtask

    initial begin
        int wr0;
        int rdy0;
        int lat;
        logic [31:0] a;
        logic [3:0]  s;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        last_rd   = '0;
        resetn    = 1'b0;
        ram_clr   = 1'b1;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, mem_ready}, 0);
        chk("rst_wr", {31'd0, ram_wr}, 0);
        chk("rst_rdata", mem_rdata, 0);
        chk("rst_addr", {20'd0, ram_addr}, 0);
        chk("rst_wdata", ram_wdata, 0);
        resetn  = 1'b1;
        ram_clr = 1'b0;

        do_txn(32'h0001_0004, 32'hDEADBEEF, 4'hF);
        chk("full_wr_val", last_wr_data, 32'hDEADBEEF);
        do_txn(32'h0001_0004, 32'h0, 4'h0);
        chk("full_rd_val", mem_rdata, 32'hDEADBEEF);
        do_txn(32'h0001_0004, 32'h0000_5500, 4'b0010);
        chk("pw_val", last_wr_data, 32'hDEAD55EF);
        do_txn(32'h0001_0004, 32'h0, 4'h0);
        do_txn(32'h0001_0004, 32'h11FF_FF22, 4'b1001);
        chk("merge_val", last_wr_data, 32'h11AD5522);
        do_txn(32'h0001_0004, 32'h0, 4'h0);

        do_txn(32'h0002_0000, 32'h0, 4'h0);
        do_txn(32'h0002_0000, 32'h1234_5678, 4'hF);
        do_txn(32'h0000_FFFC, 32'h0, 4'h0);
        do_txn(32'h0000_FFFC, 32'h1234_5678, 4'hF);

        do_txn(32'h0001_3FFC, 32'hA5A5_A5A5, 4'hF);
        chk("top_addr", {20'd0, last_wr_addr}, 32'hFFF);
        do_txn(32'h0001_0000, 32'h0, 4'h0);
        do_txn(32'h0001_3FFC, 32'h0, 4'h0);

        // reset while the partial write sits in RD_CAPTURE
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = 32'h0001_0004;
        mem_wdata = 32'h7777_7777;
        mem_wstrb = 4'b0100;
        wr0  = wr_cnt;
        rdy0 = rdy_cnt;
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", {31'd0, mem_ready}, 0);
        chk("mid_rst_wr", {31'd0, ram_wr}, 0);
        chk("mid_rst_rdata", mem_rdata, 0);
        chk("mid_rst_addr", {20'd0, ram_addr}, 0);
        chk("mid_rst_wdata", ram_wdata, 0);
        resetn    = 1'b1;
        mem_valid = 1'b0;
        last_rd   = '0;
        repeat (4) @(negedge clk);
        chk("mid_rst_no_wr", wr_cnt - wr0, 0);
        chk("mid_rst_no_ready", rdy_cnt - rdy0, 0);
        do_txn(32'h0001_0004, 32'h0, 4'h0);

        // request held through ACK: accepted again only after returning to IDLE
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = 32'h0001_0014;
        mem_wdata = 32'hCAFE_F00D;
        mem_wstrb = 4'hF;
        wr0 = wr_cnt;
        lat = 0;
        while (!mem_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("held_lat1", lat, 2);
        chk("held_wr1", wr_cnt - wr0, 1);
        @(negedge clk);
        chk("held_gap_ready", {31'd0, mem_ready}, 0);
        chk("held_gap_wr", wr_cnt - wr0, 1);
        lat = 0;
        while (!mem_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        mem_valid = 1'b0;
        chk("held_lat2", lat, 2);
        chk("held_wr2", wr_cnt - wr0, 2);
        ref_mem[5] = 32'hCAFE_F00D;
        do_txn(32'h0001_0014, 32'h0, 4'h0);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = {BASE[31:AW+2], 8'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
            case ($urandom_range(0, 2))
                0:       s = 4'h0;
                1:       s = 4'hF;
                default: s = 4'($urandom_range(1, 14));
            endcase
            do_txn(a, $urandom, s);
        end
        for (int w = 0; w < 16; w++) do_txn(BASE + 32'(w * 4), 32'h0, 4'h0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
